// File: rtl/hood_pkg.sv
// hood_pkg: channel indices, debounce FSM state and default timing for the range-hood input stage
package hood_pkg;
    localparam int CH_MENU  = 0;
    localparam int CH_SPD1  = 1;
    localparam int CH_SPD2  = 2;
    localparam int CH_SPD3  = 3;
    localparam int CH_CLEAN = 4;
    localparam int NUM_CH   = 5;
    localparam int CLK_HZ                = 100_000_000;
    localparam int DEF_SYNC_STAGES       = 2;
    localparam int DEF_DEBOUNCE_CYCLES   = CLK_HZ / 100;
    localparam int DEF_LONG_PRESS_CYCLES = CLK_HZ * 3;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronise one raw key, debounce it into a stable level and emit a one-cycle rise pulse
module debounce_channel
    import hood_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0] cnt;
    logic stable_d;
    logic sync;
    db_state_t state;
    assign sync = sync_q[SYNC_STAGES-1];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            cnt      <= '0;
            state    <= IDLE;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
            stable_d <= stable;
            rise     <= stable & ~stable_d;
            case (state)
                IDLE: if (sync) begin
                    state <= PRESS_WAIT;
                    cnt   <= CW'(1);
                end
                PRESS_WAIT: if (!sync) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (cnt == LAST) begin
                    state  <= PRESSED;
                    stable <= 1'b1;
                    cnt    <= '0;
                end else cnt <= cnt + 1'b1;
                PRESSED: if (!sync) begin
                    state <= RELEASE_WAIT;
                    cnt   <= CW'(1);
                end
                RELEASE_WAIT: if (sync) begin
                    state <= PRESSED;
                    cnt   <= '0;
                end else if (cnt == LAST) begin
                    state  <= IDLE;
                    stable <= 1'b0;
                    cnt    <= '0;
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced press pulses, one-hot speed code and menu long-press for the hood keys
module button_conditioner
    import hood_pkg::*;
#(
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       menu_raw,
    input  logic [2:0] speed_raw,
    input  logic       clean_raw,
    output logic       menu_pulse,
    output logic       menu_long,
    output logic [2:0] speed_btn,
    output logic       speed_conflict,
    output logic       clean_pulse,
    output logic [4:0] btn_level
);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_PRESS_CYCLES);
    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] rise;
    logic [2:0] spd_rise;
    logic spd_multi;
    logic [HW-1:0] hold_cnt;
    assign raw = {clean_raw, speed_raw, menu_raw};
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk(clk),
            .reset(reset),
            .raw(raw[i]),
            .stable(btn_level[i]),
            .rise(rise[i])
        );
    end
    // rise bits are already registered, so the merge stays in the pulse stage
    assign spd_rise       = rise[CH_SPD3:CH_SPD1];
    assign spd_multi      = (spd_rise & (spd_rise - 3'd1)) != 3'd0;
    assign speed_btn      = spd_multi ? 3'b000 : spd_rise;
    assign speed_conflict = spd_multi;
    assign menu_pulse     = rise[CH_MENU];
    assign clean_pulse    = rise[CH_CLEAN];
    // saturating one past the fire value keeps menu_long from re-firing until release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt  <= '0;
            menu_long <= 1'b0;
        end else begin
            menu_long <= btn_level[CH_MENU] && hold_cnt == HOLD_FIRE;
            hold_cnt  <= !btn_level[CH_MENU] ? '0 : hold_cnt == HOLD_SAT ? hold_cnt : hold_cnt + 1'b1;
        end
    end
endmodule
